// File: rtl/core_ctrl.sv
// core_ctrl: main decode/control unit of the rysy RV32I core.
// Turns opcode/func3/func7 and the comparator flag into datapath selects and
// enables. Loads take two cycles on the shared memory port, tracked by a
// single load_phase flop; every output is combinational from the inputs and
// that flop.
// Optional feature: define CTRL_ILLEGAL_NOP_EN to make unknown opcodes inject
// a NOP into the instruction stream.
module core_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       b,
  output logic [2:0] imm_type,
  output logic [1:0] inst_sel,
  output logic       reg_wr,
  output logic [3:0] alu_op,
  output logic [2:0] cmp_op,
  output logic [1:0] pc_sel,
  output logic       mem_sel,
  output logic [1:0] rd_sel,
  output logic       alu1_sel,
  output logic       alu2_sel,
  output logic [2:0] sel_type,
  output logic       we
);

  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  localparam logic [2:0] IMM_NONE = 3'b000;
  localparam logic [2:0] IMM_U    = 3'b001;
  localparam logic [2:0] IMM_J    = 3'b010;
  localparam logic [2:0] IMM_S    = 3'b011;
  localparam logic [2:0] IMM_I    = 3'b100;
  localparam logic [2:0] IMM_B    = 3'b101;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  // Address phase drives the data address; data phase writes rd back.
  typedef enum logic {
    PHASE_ADDR = 1'b0,
    PHASE_DATA = 1'b1
  } load_phase_t;

  load_phase_t load_phase;
  load_phase_t load_phase_next;
  logic [3:0]  alu_func;

  // Load phase register, cleared synchronously by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_phase <= PHASE_ADDR;
    end else begin
      load_phase <= load_phase_next;
    end
  end

  // Load phase alternates while a LOAD is presented, otherwise drops to address phase.
  always_comb begin
    load_phase_next = PHASE_ADDR;
    if (opcode == OPC_LOAD) begin
      load_phase_next = (load_phase == PHASE_ADDR) ? PHASE_DATA : PHASE_ADDR;
    end
  end

  // ALU function for register/immediate arithmetic; SUB exists only for register OP.
  always_comb begin
    alu_func = ALU_ADD;
    case (func3)
      3'b000: alu_func = (opcode == OPC_OP && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b001: alu_func = ALU_SLL;
      3'b010: alu_func = ALU_SLT;
      3'b011: alu_func = ALU_SLTU;
      3'b100: alu_func = ALU_XOR;
      3'b101: alu_func = func7[5] ? ALU_SRA : ALU_SRL;
      3'b110: alu_func = ALU_OR;
      3'b111: alu_func = ALU_AND;
      default: alu_func = ALU_ADD;
    endcase
  end

  // Output decode from the opcode, the comparator flag and the load phase.
  always_comb begin
    imm_type = IMM_NONE;
    inst_sel = 2'b00;
    reg_wr   = 1'b0;
    alu_op   = ALU_ADD;
    cmp_op   = 3'b000;
    pc_sel   = 2'b01;
    mem_sel  = 1'b0;
    rd_sel   = 2'b10;
    alu1_sel = 1'b0;
    alu2_sel = 1'b1;
    sel_type = 3'b010;
    we       = 1'b0;
    case (opcode)
      OPC_LOAD: begin
        imm_type = IMM_I;
        rd_sel   = 2'b11;
        sel_type = func3;
        if (load_phase == PHASE_ADDR) begin
          mem_sel  = 1'b1;
          pc_sel   = 2'b10;
          inst_sel = 2'b10;
        end else begin
          reg_wr = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I;
        reg_wr   = 1'b1;
        alu_op   = alu_func;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U;
        reg_wr   = 1'b1;
        alu1_sel = 1'b1;
      end
      OPC_STORE: begin
        imm_type = IMM_S;
        we       = 1'b1;
        mem_sel  = 1'b1;
        sel_type = func3;
        inst_sel = 2'b01;
      end
      OPC_OP: begin
        reg_wr   = 1'b1;
        alu2_sel = 1'b0;
        alu_op   = alu_func;
      end
      OPC_LUI: begin
        imm_type = IMM_U;
        reg_wr   = 1'b1;
        rd_sel   = 2'b00;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B;
        alu1_sel = 1'b1;
        cmp_op   = func3;
        if (b) begin
          pc_sel   = 2'b00;
          inst_sel = 2'b01;
        end
      end
      OPC_JALR: begin
        imm_type = IMM_I;
        reg_wr   = 1'b1;
        rd_sel   = 2'b01;
        pc_sel   = 2'b00;
        inst_sel = 2'b01;
      end
      OPC_JAL: begin
        imm_type = IMM_J;
        reg_wr   = 1'b1;
        rd_sel   = 2'b01;
        alu1_sel = 1'b1;
        pc_sel   = 2'b00;
        inst_sel = 2'b01;
      end
      default: begin
`ifdef CTRL_ILLEGAL_NOP_EN
        inst_sel = 2'b01;
`else
        inst_sel = 2'b00;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: self-checking bench for core_ctrl. Directed steps follow the
// decode and load-sequence behaviour, then a randomized run is compared
// against a behavioural model that tracks loads as a count of consecutive
// LOAD edges.
module tb_core_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic [2:0] func3;
  logic [6:0] func7;
  logic       b;
  logic [2:0] imm_type;
  logic [1:0] inst_sel;
  logic       reg_wr;
  logic [3:0] alu_op;
  logic [2:0] cmp_op;
  logic [1:0] pc_sel;
  logic       mem_sel;
  logic [1:0] rd_sel;
  logic       alu1_sel;
  logic       alu2_sel;
  logic [2:0] sel_type;
  logic       we;

  int errors = 0;
  int checks = 0;
  int load_run = 0;

  typedef struct packed {
    logic [2:0] imm_type;
    logic [1:0] inst_sel;
    logic       reg_wr;
    logic [3:0] alu_op;
    logic [2:0] cmp_op;
    logic [1:0] pc_sel;
    logic       mem_sel;
    logic [1:0] rd_sel;
    logic       alu1_sel;
    logic       alu2_sel;
    logic [2:0] sel_type;
    logic       we;
  } exp_t;

  core_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .func3    (func3),
    .func7    (func7),
    .b        (b),
    .imm_type (imm_type),
    .inst_sel (inst_sel),
    .reg_wr   (reg_wr),
    .alu_op   (alu_op),
    .cmp_op   (cmp_op),
    .pc_sel   (pc_sel),
    .mem_sel  (mem_sel),
    .rd_sel   (rd_sel),
    .alu1_sel (alu1_sel),
    .alu2_sel (alu2_sel),
    .sel_type (sel_type),
    .we       (we)
  );

  // Free-running core clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference load tracking: length of the current unbroken run of LOAD edges.
  always @(posedge clk) begin
    if (rst) load_run = 0;
    else if (opcode == 5'b00000) load_run = load_run + 1;
    else load_run = 0;
  end

  // Behavioural expectation computed from the instruction class rules.
  function automatic exp_t modelOutputs(input logic [4:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7, input logic br, input int run);
    exp_t e;
    logic [3:0] alu_table [8];
    bit is_load, is_opimm, is_auipc, is_store, is_op, is_lui, is_br, is_jalr, is_jal;
    bit known, second_half, jump;
    alu_table = '{4'b0000, 4'b0101, 4'b1000, 4'b1001, 4'b0010, 4'b0110, 4'b0011, 4'b0100};
    is_load  = (op == 5'b00000);
    is_opimm = (op == 5'b00100);
    is_auipc = (op == 5'b00101);
    is_store = (op == 5'b01000);
    is_op    = (op == 5'b01100);
    is_lui   = (op == 5'b01101);
    is_br    = (op == 5'b11000);
    is_jalr  = (op == 5'b11001);
    is_jal   = (op == 5'b11011);
    known = is_load | is_opimm | is_auipc | is_store | is_op | is_lui | is_br | is_jalr | is_jal;
    second_half = (run % 2) == 1;
    jump = is_jal | is_jalr;

    if (is_lui || is_auipc) e.imm_type = 3'b001;
    else if (is_jal) e.imm_type = 3'b010;
    else if (is_store) e.imm_type = 3'b011;
    else if (is_opimm || is_load || is_jalr) e.imm_type = 3'b100;
    else if (is_br) e.imm_type = 3'b101;
    else e.imm_type = 3'b000;

    e.alu_op = 4'b0000;
    if (is_op || is_opimm) begin
      e.alu_op = alu_table[f3];
      if (f3 == 3'd0 && is_op && f7[5]) e.alu_op = 4'b0001;
      if (f3 == 3'd5 && f7[5]) e.alu_op = 4'b0111;
    end

    e.cmp_op   = is_br ? f3 : 3'b000;
    e.alu1_sel = is_jal | is_auipc | is_br;
    e.alu2_sel = !is_op;
    e.rd_sel   = is_lui ? 2'b00 : jump ? 2'b01 : is_load ? 2'b11 : 2'b10;
    e.we       = is_store;
    e.mem_sel  = is_store | (is_load && !second_half);
    e.sel_type = (is_load || is_store) ? f3 : 3'b010;
    e.reg_wr   = is_load ? second_half : (known && !is_store && !is_br);

    if (jump || (is_br && br)) e.pc_sel = 2'b00;
    else if (is_load && !second_half) e.pc_sel = 2'b10;
    else e.pc_sel = 2'b01;

    if (is_load && !second_half) e.inst_sel = 2'b10;
    else if (is_store || jump || (is_br && br)) e.inst_sel = 2'b01;
`ifdef CTRL_ILLEGAL_NOP_EN
    else if (!known) e.inst_sel = 2'b01;
`endif
    else e.inst_sel = 2'b00;
    return e;
  endfunction

  task automatic checkField(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b (op=%b f3=%b f7=%b b=%b t=%0t)",
             tag, observed, expected, opcode, func3, func7, b, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic br);
    rst    = r;
    opcode = op;
    func3  = f3;
    func7  = f7;
    b      = br;
    #1;
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    e = modelOutputs(opcode, func3, func7, b, load_run);
    checkField({tag, ".imm_type"}, 4'(imm_type), 4'(e.imm_type));
    checkField({tag, ".inst_sel"}, 4'(inst_sel), 4'(e.inst_sel));
    checkField({tag, ".reg_wr"},   4'(reg_wr),   4'(e.reg_wr));
    checkField({tag, ".alu_op"},   alu_op,       e.alu_op);
    checkField({tag, ".cmp_op"},   4'(cmp_op),   4'(e.cmp_op));
    checkField({tag, ".pc_sel"},   4'(pc_sel),   4'(e.pc_sel));
    checkField({tag, ".mem_sel"},  4'(mem_sel),  4'(e.mem_sel));
    checkField({tag, ".rd_sel"},   4'(rd_sel),   4'(e.rd_sel));
    checkField({tag, ".alu1_sel"}, 4'(alu1_sel), 4'(e.alu1_sel));
    checkField({tag, ".alu2_sel"}, 4'(alu2_sel), 4'(e.alu2_sel));
    checkField({tag, ".sel_type"}, 4'(sel_type), 4'(e.sel_type));
    checkField({tag, ".we"},       4'(we),       4'(e.we));
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Directed steps, then a randomized run against the model.
  initial begin
    logic [4:0] op_list [10];
    op_list = '{5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
                5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b10101};

    applyStimulus(1'b1, 5'b01100, 3'b000, 7'b0000000, 1'b0);
    stepClock();
    applyStimulus(1'b0, 5'b01100, 3'b000, 7'b0100000, 1'b0);
    checkOutput("op_sub");
    checkField("op_sub_const", alu_op, 4'b0001);
    applyStimulus(1'b0, 5'b01100, 3'b000, 7'b0000000, 1'b0);
    checkField("op_add_const", alu_op, 4'b0000);
    checkField("op_alu2", 4'(alu2_sel), 4'd0);
    applyStimulus(1'b0, 5'b01100, 3'b010, 7'b0000000, 1'b0);
    checkField("op_slt", alu_op, 4'b1000);
    applyStimulus(1'b0, 5'b01100, 3'b100, 7'b0000000, 1'b0);
    checkField("op_xor", alu_op, 4'b0010);
    applyStimulus(1'b0, 5'b01100, 3'b001, 7'b0000000, 1'b0);
    checkField("op_sll", alu_op, 4'b0101);
    applyStimulus(1'b0, 5'b01100, 3'b101, 7'b0000000, 1'b0);
    checkField("op_srl", alu_op, 4'b0110);
    applyStimulus(1'b0, 5'b01100, 3'b101, 7'b0100000, 1'b0);
    checkField("op_sra", alu_op, 4'b0111);
    applyStimulus(1'b0, 5'b00100, 3'b000, 7'b0100000, 1'b0);
    checkOutput("opimm_addi");
    checkField("opimm_imm", 4'(imm_type), 4'b0100);
    applyStimulus(1'b0, 5'b01101, 3'b000, 7'b0000000, 1'b0);
    checkField("lui_imm", 4'(imm_type), 4'b0001);
    checkField("lui_rd", 4'(rd_sel), 4'b0000);
    applyStimulus(1'b0, 5'b01000, 3'b001, 7'b0000000, 1'b0);
    checkOutput("store");
    checkField("store_we", 4'(we), 4'd1);
    applyStimulus(1'b0, 5'b11011, 3'b000, 7'b0000000, 1'b0);
    checkOutput("jal");
    applyStimulus(1'b0, 5'b11001, 3'b000, 7'b0000000, 1'b0);
    checkField("jalr_pc", 4'(pc_sel), 4'b0000);
    checkField("jalr_inst", 4'(inst_sel), 4'b0001);
    applyStimulus(1'b0, 5'b11000, 3'b101, 7'b0000000, 1'b0);
    checkField("br_nt_pc", 4'(pc_sel), 4'b0001);
    checkField("br_nt_inst", 4'(inst_sel), 4'b0000);
    applyStimulus(1'b0, 5'b11000, 3'b101, 7'b0000000, 1'b1);
    checkField("br_t_pc", 4'(pc_sel), 4'b0000);
    checkField("br_t_inst", 4'(inst_sel), 4'b0001);
    checkField("br_t_cmp", 4'(cmp_op), 4'b0101);
    applyStimulus(1'b0, 5'b10101, 3'b000, 7'b0000000, 1'b0);
    checkOutput("illegal");
    checkField("illegal_reg_wr", 4'(reg_wr), 4'd0);

    applyStimulus(1'b1, 5'b00000, 3'b010, 7'b0000000, 1'b0);
    stepClock();
    checkField("ld_rst_pc", 4'(pc_sel), 4'b0010);
    checkField("ld_rst_inst", 4'(inst_sel), 4'b0010);
    checkField("ld_rst_mem", 4'(mem_sel), 4'd1);
    checkField("ld_rst_wr", 4'(reg_wr), 4'd0);
    applyStimulus(1'b0, 5'b00000, 3'b010, 7'b0000000, 1'b0);
    stepClock();
    checkField("ld_p1_pc", 4'(pc_sel), 4'b0001);
    checkField("ld_p1_wr", 4'(reg_wr), 4'd1);
    checkOutput("ld_p1");
    stepClock();
    checkField("ld_p0_again_pc", 4'(pc_sel), 4'b0010);
    stepClock();
    checkField("ld_p1_again_wr", 4'(reg_wr), 4'd1);
    applyStimulus(1'b0, 5'b00100, 3'b000, 7'b0000000, 1'b0);
    checkField("ld_sw_wr", 4'(reg_wr), 4'd1);
    checkField("ld_sw_pc", 4'(pc_sel), 4'b0001);
    stepClock();
    applyStimulus(1'b0, 5'b00000, 3'b000, 7'b0000000, 1'b0);
    checkField("ld_cleared_pc", 4'(pc_sel), 4'b0010);
    stepClock();
    applyStimulus(1'b1, 5'b00000, 3'b000, 7'b0000000, 1'b0);
    stepClock();
    checkField("ld_midrst_pc", 4'(pc_sel), 4'b0010);

    for (int i = 0; i < 400; i++) begin
      logic [4:0] op;
      op = op_list[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) op = 5'($urandom);
      if ($urandom_range(0, 2) == 0) op = 5'b00000;
      applyStimulus(($urandom_range(0, 15) == 0), op, 3'($urandom), 7'($urandom), 1'($urandom));
      checkOutput("rand");
      stepClock();
      checkOutput("rand_post");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
